// File: rtl/load_store_unit.sv
// Load/store controller between the CPU datapath and a word-addressed data memory.
// Sub-word stores are read-modify-write; loads return extended data with a one-cycle pulse.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_write;
    logic        r_unsigned;
    logic        r_error;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_merged;

    logic        w_illegal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic [31:0] w_merge;

    always_comb begin
        w_illegal = 1'b0;
        unique case (req_size)
            2'b00:   w_illegal = 1'b0;
            2'b01:   w_illegal = req_addr[0];
            2'b10:   w_illegal = |req_addr[1:0];
            default: w_illegal = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS) begin
            w_illegal = 1'b1;
        end
    end

    // Little-endian lane select from the combinational memory read.
    always_comb begin
        w_byte = mem_read_data[7:0];
        case (r_addr[1:0])
            2'b01:   w_byte = mem_read_data[15:8];
            2'b10:   w_byte = mem_read_data[23:16];
            2'b11:   w_byte = mem_read_data[31:24];
            default: w_byte = mem_read_data[7:0];
        endcase
        w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (r_size)
            2'b00:   w_ext = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ext = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ext = mem_read_data;
        endcase
    end

    always_comb begin
        w_merge = mem_read_data;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'b01:   w_merge[15:8]  = r_wdata[7:0];
                2'b10:   w_merge[23:16] = r_wdata[7:0];
                2'b11:   w_merge[31:24] = r_wdata[7:0];
                default: w_merge[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_error    <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_merged   <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && req_valid) begin
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_size     <= req_size;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_error    <= w_illegal;
                r_rdata    <= 32'h0;
            end
            if (r_state == StAccess) begin
                if (!r_write) begin
                    r_rdata <= w_ext;
                end
                r_merged <= w_merge;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_error     = 1'b0;
        resp_rdata     = 32'h0;
        mem_write      = 1'b0;
        mem_address    = 32'h0;
        mem_write_data = 32'h0;
        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = w_illegal ? StResp : StAccess;
                end
            end
            StAccess: begin
                mem_address = {r_addr[31:2], 2'b00};
                if (!r_write) begin
                    w_state_next = StResp;
                end else if (r_size == 2'b10) begin
                    mem_write      = 1'b1;
                    mem_write_data = r_wdata;
                    w_state_next   = StResp;
                end else begin
                    w_state_next = StWrite;
                end
            end
            StWrite: begin
                mem_address    = {r_addr[31:2], 2'b00};
                mem_write      = 1'b1;
                mem_write_data = r_merged;
                w_state_next   = StResp;
            end
            StResp: begin
                resp_valid   = 1'b1;
                resp_error   = r_error;
                resp_rdata   = (r_write || r_error) ? 32'h0 : r_rdata;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of requests with a response scoreboard, plus
// hand-written handshake and reset-during-write sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_error     (resp_error),
        .resp_rdata     (resp_rdata),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    logic [31:0] mem [256];
    logic        mem_init;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          last_wr_cyc = 0;
    logic [31:0] last_wr_data = 32'h0;
    int          resp_cnt = 0;

    assign mem_read_data = mem[mem_address[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h0000_0005;
            mem[1] <= 32'h0000_000A;
            mem[2] <= 32'h0000_000F;
        end else if (mem_write) begin
            mem[mem_address[9:2]] <= mem_write_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_cyc  <= cyc;
            last_wr_data <= mem_write_data;
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
        logic [31:0] mdata;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                fail_now("unexpected_resp");
            end else begin
                e = sb.pop_front();
                check("resp_error", {31'h0, resp_error}, {31'h0, e.err});
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic err, input logic [31:0] rdata, input int lat,
                                input int nwr, input logic [31:0] mdata);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.err = err; v.rdata = rdata; v.lat = lat; v.nwr = nwr; v.mdata = mdata;
        return v;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            fail_now(name);
            sb.delete();
        end
    endtask

    task automatic issue(input vec_t v, input int idx);
        int   n = 0;
        int   acc;
        int   wr0;
        exp_t e;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now($sformatf("vec%0d_ready_timeout", idx));
            return;
        end
        req_write    = v.wr;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        wr0          = wr_cnt;
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        e.err   = v.err;
        e.rdata = v.rdata;
        e.cyc   = acc + v.lat - 1;
        sb.push_back(e);
        wait_drain($sformatf("vec%0d_resp_timeout", idx));
        check($sformatf("vec%0d_write_count", idx), wr_cnt - wr0, v.nwr);
        if (v.nwr != 0) begin
            check($sformatf("vec%0d_write_cycle", idx), last_wr_cyc, acc + v.lat - 2);
            check($sformatf("vec%0d_write_data", idx), last_wr_data, v.mdata);
        end
    endtask

    initial begin
        int   acc;
        int   wr0;
        int   rc0;
        exp_t e;

        rst_n = 1'b0; mem_init = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_error", {31'h0, resp_error}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_init = 1'b0;

        //             wr  size   uns addr          wdata         err rdata         lat nwr mdata
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0004, 32'h0,        0, 32'h0000_000A, 2, 0, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0009, 32'h1234_56AB, 0, 32'h0,        3, 1, 32'h0000_AB0F));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0009, 32'h0,        0, 32'hFFFF_FFAB, 2, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h0000_0009, 32'h0,        0, 32'h0000_00AB, 2, 0, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0002, 32'h0000_8001, 0, 32'h0,        3, 1, 32'h8001_0005));
        vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0002, 32'h0,        0, 32'hFFFF_8001, 2, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h0000_0000, 32'h0,        0, 32'h0000_0005, 2, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0006, 32'h0,        1, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0400, 32'hDEAD_BEEF, 1, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0000, 32'h0,        0, 32'h8001_0005, 2, 0, 32'h0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h0000_0000, 32'h0,        1, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0003, 32'h0000_FFFF, 1, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0400, 32'h0,        1, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0000_03FC, 32'hDEAD_BEEF, 0, 32'h0,        2, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0000_03FF, 32'h0,        0, 32'hFFFF_FFDE, 2, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h0000_03FC, 32'h0,        0, 32'h0000_BEEF, 2, 0, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0008, 32'h0000_007F, 0, 32'h0,        3, 1, 32'h0000_AB7F));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0008, 32'h0,        0, 32'h0000_007F, 2, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0008, 32'h0,        0, 32'h0000_AB7F, 2, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0001, 32'h0,        1, 32'h0,        1, 0, 32'h0));

        foreach (vecs[i]) issue(vecs[i], i);

        // Two word stores with req_valid held high across the busy cycles.
        while (!req_ready) @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h1111_1111; req_valid = 1'b1;
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        acc = cyc;
        req_addr = 32'h24; req_wdata = 32'h2222_2222;
        e.err = 1'b0; e.rdata = 32'h0; e.cyc = acc + 1; sb.push_back(e);
        e.cyc = acc + 4; sb.push_back(e);
        check("hs_ready_access", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("hs_ready_resp", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("hs_ready_idle", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_drain("hs_resp_timeout");
        check("hs_write_count", wr_cnt - wr0, 32'd2);
        check("hs_mem_first", mem[8], 32'h1111_1111);
        check("hs_mem_second", mem[9], 32'h2222_2222);

        // Byte store with reset sampled at the edge that ends the WRITE cycle.
        while (!req_ready) @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h0000_0055;
        req_valid = 1'b1;
        wr0 = wr_cnt;
        rc0 = resp_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_mem", mem[4], 32'h0000_5500);
        check("mid_rst_write_count", wr_cnt - wr0, 32'd1);
        check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        check("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("mid_rst_resp_rdata", resp_rdata, 32'h0);
        check("mid_rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("mid_rst_mem_address", mem_address, 32'h0);
        check("mid_rst_mem_wdata", mem_write_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("mid_rst_no_resp", resp_cnt - rc0, 32'd0);
        check("mid_rst_no_extra_write", wr_cnt - wr0, 32'd1);

        issue(mk(0, 2'b00, 1, 32'h0000_0011, 32'h0, 0, 32'h0000_0055, 2, 0, 32'h0), 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule
